// File: rtl/rgmii_rx_mac_if.sv
// rtl/rgmii_rx_mac_if.sv - payload stream interface for the RGMII RX MAC framer
//
// Purpose: carries the framed payload out of rgmii_rx_mac. There is no tready;
// the sink must accept every byte presented with tvalid.
//
// Signals:
//   tdata   8  payload byte (holds its last value while tvalid=0)
//   tvalid  1  one-cycle pulse per payload byte
//   tlast   1  last payload byte of the frame
//   tuser   1  qualified by tlast: 1 = bad frame
//
// Modports: master (framer side, drives), slave (sink side, observes).

interface rgmii_rx_mac_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser
  );

  modport slave (
    input tdata,
    input tvalid,
    input tlast,
    input tuser
  );
endinterface

// File: rtl/rgmii_rx_mac.sv
// rtl/rgmii_rx_mac.sv - RGMII RX MAC framer: preamble/SFD strip, FCS check and strip
//
// Purpose: consumes beat-qualified bytes from the RGMII PHY interface, strips the
// preamble and SFD, runs a reflected CRC-32 over every byte after the SFD, holds the
// last four bytes back so the FCS never reaches the output, and flags bad frames on
// tuser together with tlast.
//
// Parameters:
//   MAX_FRAME  max bytes after SFD incl. FCS; longer frames are truncated and flagged bad
//   MIN_FRAME  min bytes after SFD incl. FCS; shorter frames are flagged bad
//
// Ports:
//   rgmii_mac_rx_clk  in   RX clock, all logic on posedge
//   reset_n           in   synchronous active-low reset
//   rx_data[7:0]      in   received byte, bit0 first on the wire
//   rx_dv             in   data valid for this beat
//   rx_er             in   receive error for this beat
//   rx_rdy            in   beat strobe; inputs are only sampled when 1
//   m_axis            out  payload stream (rgmii_rx_mac_if.master)
//
// Optional build macro RX_MAC_STATS_EN adds:
//   stat_good_frames[31:0]  out  saturating count of good frames
//   stat_bad_frames[31:0]   out  saturating count of bad frames (incl. silent short discards)

module rgmii_rx_mac #(
  parameter int MAX_FRAME = 1518,
  parameter int MIN_FRAME = 64
) (
  input  logic                 rgmii_mac_rx_clk,
  input  logic                 reset_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_dv,
  input  logic                 rx_er,
  input  logic                 rx_rdy,
  rgmii_rx_mac_if.master       m_axis
`ifdef RX_MAC_STATS_EN
  ,
  output logic [31:0]          stat_good_frames,
  output logic [31:0]          stat_bad_frames
`endif
);

  // Count must be able to hold MAX_FRAME+1, where it saturates.
  localparam int          CNT_W   = $clog2(MAX_FRAME + 2);
  localparam logic [31:0] CRC_RES = 32'hDEBB20E3;
  localparam logic [31:0] CRC_INI = 32'hFFFFFFFF;
  localparam logic [7:0]  PRE_B   = 8'h55;
  localparam logic [7:0]  SFD_B   = 8'hD5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_PAYLOAD,
    ST_DROP
  } state_t;

  state_t           state_q, state_d;
  // sh_q[0] is the newest byte, sh_q[4] the oldest (next to be emitted).
  logic [4:0][7:0]  sh_q, sh_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      crc_q, crc_d;
  logic             err_q, err_d;
  logic [7:0]       tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic             tuser_q, tuser_d;

  logic             have_pending;
  logic             at_max;
  logic             frame_bad;

  // Reflected CRC-32, one byte per call, LSB of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // Five bytes received means the oldest one is definitely not part of the FCS.
  assign have_pending = (count_q >= CNT_W'(5));
  assign at_max       = (count_q == CNT_W'(MAX_FRAME));
  // Evaluated on the dv=0 end beat, so crc_q already covers all N bytes.
  assign frame_bad    = (crc_q != CRC_RES) | err_q | rx_er | (count_q < CNT_W'(MIN_FRAME));

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    count_d  = count_q;
    crc_d    = crc_q;
    err_d    = err_q;
    tdata_d  = tdata_q;
    tvalid_d = 1'b0;
    tlast_d  = 1'b0;
    tuser_d  = 1'b0;

    if (rx_rdy) begin
      unique case (state_q)
        ST_IDLE: begin
          if (rx_dv && (rx_data == PRE_B)) begin
            state_d = ST_PREAMBLE;
          end
        end

        ST_PREAMBLE: begin
          if (!rx_dv) begin
            state_d = ST_IDLE;
          end else if (rx_er) begin
            state_d = ST_DROP;
          end else if (rx_data == PRE_B) begin
            state_d = ST_PREAMBLE;
          end else if (rx_data == SFD_B) begin
            state_d = ST_PAYLOAD;
            crc_d   = CRC_INI;
            count_d = '0;
            err_d   = 1'b0;
            sh_d    = '0;
          end else begin
            state_d = ST_DROP;
          end
        end

        ST_PAYLOAD: begin
          if (rx_dv) begin
            if (at_max) begin
              // This byte would push the frame past MAX_FRAME: close it out as bad
              // with the byte already waiting, and ignore the rest of the frame.
              tdata_d  = sh_q[4];
              tvalid_d = 1'b1;
              tlast_d  = 1'b1;
              tuser_d  = 1'b1;
              count_d  = count_q + CNT_W'(1);
              state_d  = ST_DROP;
            end else begin
              if (have_pending) begin
                tdata_d  = sh_q[4];
                tvalid_d = 1'b1;
              end
              sh_d    = {sh_q[3:0], rx_data};
              crc_d   = crc32_byte(crc_q, rx_data);
              count_d = count_q + CNT_W'(1);
              err_d   = err_q | rx_er;
            end
          end else begin
            state_d = ST_IDLE;
            // Fewer than five bytes: nothing ever left the shift line, so the frame
            // vanishes without a tlast.
            if (have_pending) begin
              tdata_d  = sh_q[4];
              tvalid_d = 1'b1;
              tlast_d  = 1'b1;
              tuser_d  = frame_bad;
            end
          end
        end

        ST_DROP: begin
          if (!rx_dv) begin
            state_d = ST_IDLE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge rgmii_mac_rx_clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      sh_q     <= '0;
      count_q  <= '0;
      crc_q    <= CRC_INI;
      err_q    <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      count_q  <= count_d;
      crc_q    <= crc_d;
      err_q    <= err_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tuser  = tuser_q;

`ifdef RX_MAC_STATS_EN
  logic [31:0] stat_good_q, stat_good_d;
  logic [31:0] stat_bad_q, stat_bad_d;
  logic        short_drop;
  logic        end_good;
  logic        end_bad;

  // Silent end of a frame that never produced output (N < 5).
  assign short_drop = rx_rdy & (state_q == ST_PAYLOAD) & ~rx_dv & ~have_pending;
  assign end_good   = tlast_d & ~tuser_d;
  assign end_bad    = (tlast_d & tuser_d) | short_drop;

  always_comb begin
    stat_good_d = stat_good_q;
    stat_bad_d  = stat_bad_q;
    if (end_good && (stat_good_q != 32'hFFFFFFFF)) begin
      stat_good_d = stat_good_q + 32'd1;
    end
    if (end_bad && (stat_bad_q != 32'hFFFFFFFF)) begin
      stat_bad_d = stat_bad_q + 32'd1;
    end
  end

  always_ff @(posedge rgmii_mac_rx_clk) begin
    if (!reset_n) begin
      stat_good_q <= '0;
      stat_bad_q  <= '0;
    end else begin
      stat_good_q <= stat_good_d;
      stat_bad_q  <= stat_bad_d;
    end
  end

  assign stat_good_frames = stat_good_q;
  assign stat_bad_frames  = stat_bad_q;
`endif

endmodule
